// File: rtl/ahb3lite_mem_slave.sv
// ahb3lite_mem_slave: AHB3-Lite responder over a word-organised single-port memory with a two-cycle ERROR response.
// Optional wait states are built only when AHB_MEM_SLV_WAIT_EN is defined.
module ahb3lite_mem_slave #(
   parameter int DATA_SIZE   = 32,
   parameter int ADDR_SIZE   = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic                 HRESETn,
   input  logic                 HCLK,
   input  logic                 HSEL,
   input  logic [ADDR_SIZE-1:0] HADDR,
   input  logic [DATA_SIZE-1:0] HWDATA,
   output logic [DATA_SIZE-1:0] HRDATA,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [2:0]           HBURST,
   input  logic [3:0]           HPROT,
   input  logic [1:0]           HTRANS,
   input  logic                 HMASTLOCK,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP
);
   localparam int BYTES  = DATA_SIZE / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ERR1 = 2'd1,
      S_ERR2 = 2'd2
`ifdef AHB_MEM_SLV_WAIT_EN
      , S_WAIT = 2'd3
`endif
   } state_t;

   logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

   state_t               state_reg;
   logic                 wr_pend_reg;
   logic [IDX_W-1:0]     wr_idx_reg;
   logic [BYTES-1:0]     wr_be_reg;

   logic [ADDR_SIZE-1:0] idx_full;
   logic [IDX_W-1:0]     idx_next;
   logic [LANE_W-1:0]    offset;
   logic [LANE_W-1:0]    align_mask;
   logic [BYTES-1:0]     be_next;
   logic                 accept;
   logic                 legal;
   logic                 wr_fire;
   logic [DATA_SIZE-1:0] rd_word;
   logic [DATA_SIZE-1:0] rd_fwd;

`ifdef AHB_MEM_SLV_WAIT_EN
   localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   logic [CNT_W-1:0] wait_cnt_reg;
`else
   localparam int unused_wait_states = WAIT_STATES;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   assign accept     = HSEL & HREADY & HREADYOUT & HTRANS[1];
   assign idx_full   = HADDR >> LANE_W;
   assign idx_next   = idx_full[IDX_W-1:0];
   assign offset     = HADDR[LANE_W-1:0];
   assign align_mask = LANE_W'((8'd1 << HSIZE) - 8'd1);
   assign legal      = (idx_full < ADDR_SIZE'(MEM_DEPTH)) &&
                       (HSIZE <= 3'(LANE_W)) &&
                       ((offset & align_mask) == '0);

   // The pending write retires on every edge where this slave is ready.
   assign wr_fire = wr_pend_reg & HREADYOUT;
   assign rd_word = mem[idx_next];

   // A lane is enabled when it sits in the same naturally aligned block as the address.
   for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign be_next[gi] = ((LANE_W'(gi) >> HSIZE) == (offset >> HSIZE));
      assign rd_fwd[gi*8 +: 8] = (wr_fire && wr_be_reg[gi] && (wr_idx_reg == idx_next)) ?
                                 HWDATA[gi*8 +: 8] : rd_word[gi*8 +: 8];
   end

   always_ff @(posedge HCLK) begin
      if (wr_fire) begin
         for (int i = 0; i < BYTES; i++) begin
            if (wr_be_reg[i]) mem[wr_idx_reg][i*8 +: 8] <= HWDATA[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg   <= S_IDLE;
         HREADYOUT   <= 1'b1;
         HRESP       <= 1'b0;
         HRDATA      <= '0;
         wr_pend_reg <= 1'b0;
         wr_idx_reg  <= '0;
         wr_be_reg   <= '0;
`ifdef AHB_MEM_SLV_WAIT_EN
         wait_cnt_reg <= '0;
`endif
      end else begin
         case (state_reg)
            S_ERR1: begin
               state_reg <= S_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
`ifdef AHB_MEM_SLV_WAIT_EN
            S_WAIT: begin
               if (wait_cnt_reg == '0) begin
                  state_reg <= S_IDLE;
                  HREADYOUT <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
               end
            end
`endif
            default: begin
               // IDLE and ERR2 both end a data phase here and may take a new address phase.
               state_reg   <= S_IDLE;
               HREADYOUT   <= 1'b1;
               HRESP       <= 1'b0;
               wr_pend_reg <= accept & legal & HWRITE;
               if (accept) begin
                  if (!legal) begin
                     state_reg <= S_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end else begin
                     wr_idx_reg <= idx_next;
                     wr_be_reg  <= be_next;
                     if (!HWRITE) HRDATA <= rd_fwd;
`ifdef AHB_MEM_SLV_WAIT_EN
                     if (WAIT_STATES > 0) begin
                        state_reg    <= S_WAIT;
                        HREADYOUT    <= 1'b0;
                        wait_cnt_reg <= CNT_W'(WAIT_STATES - 1);
                     end
`endif
                  end
               end
            end
         endcase
      end
   end
endmodule
